// File: rtl/wb_burst_initiator.sv
// Wishbone B3 initiator: turns a command + write-data stream into single or incrementing bursts.
// Latency: accept at T -> cyc/stb at T+1; last ack at C -> done_valid at C+1, cmd_ready at C+2.
// Backpressure: cmd_ready only in IDLE; stb drops while wdata_valid is low; rdata has no backpressure.
//
// Ports: cmd_*  command (we/adr/sel/len) handshake
//        wdata* write beat stream, wdata_ready pulses with each write-beat ack
//        rdata* registered read beats, rdata_last marks the final beat of a command
//        done_* one-cycle completion status (error flag, beats acked)
//        wb_*   Wishbone B3 master port (clk/rst_n shared with the rest of the block)
module wb_burst_initiator #(
  parameter int MAX_RETRY = 4,
  parameter int LEN_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_adr,
  input  logic [3:0]       cmd_sel,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      wdata,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  output logic [31:0]      rdata,
  output logic             rdata_valid,
  output logic             rdata_last,
  output logic             done_valid,
  output logic             done_err,
  output logic [LEN_W:0]   done_beats,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  output logic [3:0]       wb_sel_o,
  output logic             wb_we_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic [2:0]       wb_cti_o,
  output logic [1:0]       wb_bte_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  input  logic             wb_rty_i,
  input  logic [31:0]      wb_dat_i
);

  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_GAP, S_DONE} state_t;

  state_t           state, state_nx;
  logic             we_q;
  logic [31:0]      adr_q;
  logic [3:0]       sel_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0]   beat_q;   // beats acked so far; also index of the beat on the bus
  logic [RTY_W-1:0] rty_q;
  logic             err_q;

  logic stb_c, is_last, rty_last;
  logic resp_ack, resp_err, resp_rty;

  // Writes only strobe when a data beat is available (master wait state otherwise).
  assign stb_c    = (state == S_BUS) && (!we_q || wdata_valid);
  assign is_last  = (beat_q == {1'b0, len_q});
  assign rty_last = (rty_q == RTY_W'(MAX_RETRY - 1));

  // Termination priority: err over rty over ack; responses only count with stb.
  assign resp_err = stb_c && wb_err_i;
  assign resp_rty = stb_c && !wb_err_i && wb_rty_i;
  assign resp_ack = stb_c && !wb_err_i && !wb_rty_i && wb_ack_i;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (cmd_valid) state_nx = S_BUS;
      S_BUS: begin
        if (resp_err)                 state_nx = S_DONE;
        else if (resp_rty)            state_nx = rty_last ? S_DONE : S_GAP;
        else if (resp_ack && is_last) state_nx = S_DONE;
      end
      S_GAP:   state_nx = S_BUS;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    done_valid  = 1'b0;
    done_err    = 1'b0;
    done_beats  = '0;
    wb_adr_o    = '0;
    wb_dat_o    = '0;
    wb_sel_o    = '0;
    wb_we_o     = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_cti_o    = 3'b000;
    wb_bte_o    = 2'b00;
    unique case (state)
      S_IDLE: cmd_ready = rst_n;
      S_BUS: begin
        wb_cyc_o    = 1'b1;
        wb_stb_o    = stb_c;
        wb_we_o     = we_q;
        wb_sel_o    = sel_q;
        wb_dat_o    = we_q ? wdata : 32'h0;
        // Address wraps modulo 2^32; bursts are never split at boundaries.
        wb_adr_o    = adr_q + (32'(beat_q) << 2);
        wb_cti_o    = (len_q == '0) ? 3'b000 : (is_last ? 3'b111 : 3'b010);
        wdata_ready = resp_ack && we_q;
      end
      S_DONE: begin
        done_valid = 1'b1;
        done_err   = err_q;
        done_beats = beat_q;
      end
      default: ;
    endcase
  end

  // Command latch, counters and read-data register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      rty_q       <= '0;
      err_q       <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      if (state == S_IDLE && cmd_valid) begin
        we_q   <= cmd_we;
        adr_q  <= cmd_adr;
        sel_q  <= cmd_sel;
        len_q  <= cmd_len;
        beat_q <= '0;
        rty_q  <= '0;
        err_q  <= 1'b0;
      end else if (resp_err) begin
        err_q <= 1'b1;
      end else if (resp_rty) begin
        rty_q <= rty_q + 1'b1;
        if (rty_last) err_q <= 1'b1;
      end else if (resp_ack) begin
        beat_q <= beat_q + 1'b1;
        rty_q  <= '0;
        if (!we_q) begin
          rdata       <= wb_dat_i;
          rdata_valid <= 1'b1;
          rdata_last  <= is_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_initiator.sv
// Directed bench for wb_burst_initiator with a zero-wait Wishbone memory responder
// that can inject rty (N times at one address) and err (at one address).
// Each test task drives a command, records what happened per cycle, and compares inline.
module tb_wb_burst_initiator;
  localparam int LEN_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, cmd_valid, cmd_ready, cmd_we;
  logic [31:0]      cmd_adr;
  logic [3:0]       cmd_sel;
  logic [LEN_W-1:0] cmd_len;
  logic [31:0]      wdata, rdata;
  logic             wdata_valid, wdata_ready, rdata_valid, rdata_last;
  logic             done_valid, done_err;
  logic [LEN_W:0]   done_beats;
  logic [31:0]      wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]       wb_sel_o;
  logic             wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, wb_rty_i;
  logic [2:0]       wb_cti_o;
  logic [1:0]       wb_bte_o;

  wb_burst_initiator #(.MAX_RETRY(4), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_last(rdata_last),
    .done_valid(done_valid), .done_err(done_err), .done_beats(done_beats),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_dat_i(wb_dat_i)
  );

  // ---------------- responder ----------------
  logic [31:0] mem [0:255];
  logic        err_en;
  logic [31:0] err_adr_t, rty_adr_t;
  int          rty_target, rty_seen;

  assign wb_err_i = wb_cyc_o && wb_stb_o && err_en && (wb_adr_o == err_adr_t);
  assign wb_rty_i = wb_cyc_o && wb_stb_o && !wb_err_i && (rty_seen < rty_target) && (wb_adr_o == rty_adr_t);
  assign wb_ack_i = wb_cyc_o && wb_stb_o && !wb_err_i && !wb_rty_i;
  assign wb_dat_i = mem[wb_adr_o[9:2]];

  always @(posedge clk) begin
    if (wb_rty_i) rty_seen <= rty_seen + 1;
    if (wb_ack_i && wb_we_o) mem[wb_adr_o[9:2]] <= wb_dat_o;
  end

  // ---------------- per-command observations ----------------
  int n_chk = 0, n_fail = 0;
  logic [31:0] wr_data[$];
  int          stall_at, stall_n;
  logic [31:0] ack_adr[$], rty_adr[$], err_adr[$], rd_dat[$];
  logic [2:0]  ack_cti[$];
  logic        rd_last[$];
  int          cyc_cnt, stbl_cnt, gap_cnt, done_cyc, first_cyc, wcons;
  logic        done_seen, d_err, stbl_cti_bad, rd_at_done, rdy_at_done, rdy_after;
  logic [LEN_W:0] d_beats;

  task automatic issue(input logic we, input logic [31:0] adr, input logic [LEN_W-1:0] len);
    @(negedge clk);
    cmd_we = we; cmd_adr = adr; cmd_sel = 4'hF; cmd_len = len; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Steps cycles (sampling #1 after the falling edge) until done_valid or the budget runs out.
  task automatic run(input int budget);
    int widx = 0;
    ack_adr.delete(); ack_cti.delete(); rty_adr.delete(); err_adr.delete();
    rd_dat.delete(); rd_last.delete();
    cyc_cnt = 0; stbl_cnt = 0; gap_cnt = 0; done_cyc = -1; first_cyc = -1;
    done_seen = 0; d_err = 0; d_beats = '0; stbl_cti_bad = 0;
    rd_at_done = 0; rdy_at_done = 0; rdy_after = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      wdata       = (widx < wr_data.size()) ? wr_data[widx] : 32'h0;
      wdata_valid = (widx < wr_data.size()) && !(c >= stall_at && c < stall_at + stall_n);
      #1;
      if (wb_cyc_o) begin
        cyc_cnt++;
        if (first_cyc < 0) first_cyc = c;
        if (!wb_stb_o) begin
          stbl_cnt++;
          if (wb_cti_o !== 3'b010) stbl_cti_bad = 1;
        end
      end
      if (wb_err_i) err_adr.push_back(wb_adr_o);
      else if (wb_rty_i) rty_adr.push_back(wb_adr_o);
      else if (wb_ack_i) begin ack_adr.push_back(wb_adr_o); ack_cti.push_back(wb_cti_o); end
      if (wdata_ready) widx++;
      if (rdata_valid) begin rd_dat.push_back(rdata); rd_last.push_back(rdata_last); end
      if (!wb_cyc_o && !done_valid) gap_cnt++;
      if (done_valid) begin
        done_seen = 1; d_err = done_err; d_beats = done_beats; done_cyc = c;
        rd_at_done = rdata_valid; rdy_at_done = cmd_ready;
        @(negedge clk);
        wdata_valid = 1'b0;
        #1 rdy_after = cmd_ready;
        break;
      end
    end
    wdata_valid = 1'b0;
    wcons = widx;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    n_chk++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_bte_o} !== 8'h0) begin n_fail++; $display("FAIL reset_wb_ctl: got %b want 0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_bte_o}); end
    n_chk++; if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 68'h0) begin n_fail++; $display("FAIL reset_wb_bus: adr %h dat %h sel %h want 0", wb_adr_o, wb_dat_o, wb_sel_o); end
    n_chk++; if ({wdata_ready, rdata_valid, rdata_last, done_valid, done_err, done_beats, rdata} !== 42'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", {wdata_ready, rdata_valid, rdata_last, done_valid, done_err, done_beats, rdata}); end
    rst_n = 1'b1;
    #1;
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_single;
    wr_data = '{32'hDEADBEEF}; stall_n = 0;
    issue(1'b1, 32'h100, 4'd0);
    run(20);
    n_chk++; if (done_seen !== 1'b1) begin n_fail++; $display("FAIL sw_done_seen: got %b want 1", done_seen); end
    n_chk++; if (first_cyc !== 0) begin n_fail++; $display("FAIL sw_cyc_latency: got %0d want 0", first_cyc); end
    n_chk++; if (ack_adr.size() !== 1 || ack_adr[0] !== 32'h100 || ack_cti[0] !== 3'b000) begin n_fail++; $display("FAIL sw_beat: acks %0d adr %h cti %b want 1/100/000", ack_adr.size(), ack_adr[0], ack_cti[0]); end
    n_chk++; if (cyc_cnt !== 1 || done_cyc !== 1) begin n_fail++; $display("FAIL sw_timing: cyc %0d done@%0d want 1/1", cyc_cnt, done_cyc); end
    n_chk++; if (d_err !== 1'b0 || d_beats !== 5'd1) begin n_fail++; $display("FAIL sw_status: err %b beats %0d want 0/1", d_err, d_beats); end
    n_chk++; if (rdy_at_done !== 1'b0 || rdy_after !== 1'b1) begin n_fail++; $display("FAIL sw_ready: at_done %b after %b want 0/1", rdy_at_done, rdy_after); end
    n_chk++; if (wcons !== 1 || mem[8'h40] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_mem: consumed %0d mem %h want 1/deadbeef", wcons, mem[8'h40]); end
    wr_data.delete();
    issue(1'b0, 32'h100, 4'd0);
    run(20);
    n_chk++; if (rd_dat.size() !== 1 || rd_dat[0] !== 32'hDEADBEEF || rd_last[0] !== 1'b1) begin n_fail++; $display("FAIL sr_data: n %0d dat %h last %b want 1/deadbeef/1", rd_dat.size(), rd_dat[0], rd_last[0]); end
    n_chk++; if (rd_at_done !== 1'b1 || done_cyc !== 1 || d_beats !== 5'd1 || d_err !== 1'b0) begin n_fail++; $display("FAIL sr_done: rd@done %b done@%0d beats %0d err %b want 1/1/1/0", rd_at_done, done_cyc, d_beats, d_err); end
  endtask

  task automatic test_burst;
    wr_data.delete();
    for (int i = 0; i < 8; i++) wr_data.push_back(32'(i));
    stall_n = 0;
    issue(1'b1, 32'h2000, 4'd7);
    run(30);
    n_chk++; if (ack_adr.size() !== 8) begin n_fail++; $display("FAIL bw_nbeats: got %0d want 8", ack_adr.size()); end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (i >= ack_adr.size() || ack_adr[i] !== 32'h2000 + 32'(4 * i) || ack_cti[i] !== ((i < 7) ? 3'b010 : 3'b111)) begin
        n_fail++; $display("FAIL bw_beat%0d: adr %h cti %b want %h/%b", i, (i < ack_adr.size()) ? ack_adr[i] : 32'hx,
                           (i < ack_cti.size()) ? ack_cti[i] : 3'bx, 32'h2000 + 32'(4 * i), (i < 7) ? 3'b010 : 3'b111);
      end
    end
    n_chk++; if (cyc_cnt !== 8 || done_cyc !== 8 || d_beats !== 5'd8 || d_err !== 1'b0 || rdy_after !== 1'b1) begin n_fail++; $display("FAIL bw_done: cyc %0d done@%0d beats %0d err %b rdy %b want 8/8/8/0/1", cyc_cnt, done_cyc, d_beats, d_err, rdy_after); end
    wr_data.delete();
    issue(1'b0, 32'h2000, 4'd7);
    run(30);
    n_chk++; if (rd_dat.size() !== 8 || d_beats !== 5'd8 || rd_at_done !== 1'b1) begin n_fail++; $display("FAIL br_done: n %0d beats %0d rd@done %b want 8/8/1", rd_dat.size(), d_beats, rd_at_done); end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (i >= rd_dat.size() || rd_dat[i] !== 32'(i) || rd_last[i] !== (i == 7)) begin
        n_fail++; $display("FAIL br_beat%0d: dat %h last %b want %h/%b", i, (i < rd_dat.size()) ? rd_dat[i] : 32'hx,
                           (i < rd_last.size()) ? rd_last[i] : 1'bx, 32'(i), (i == 7));
      end
    end
  endtask

  task automatic test_wait_states;
    wr_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    stall_at = 2; stall_n = 3;
    issue(1'b1, 32'h3000, 4'd3);
    run(30);
    stall_n = 0;
    n_chk++; if (cyc_cnt !== 7 || stbl_cnt !== 3 || stbl_cti_bad !== 1'b0) begin n_fail++; $display("FAIL ws_stall: cyc %0d stb_low %0d cti_bad %b want 7/3/0", cyc_cnt, stbl_cnt, stbl_cti_bad); end
    n_chk++; if (ack_adr.size() !== 4 || ack_adr[2] !== 32'h3008 || ack_adr[3] !== 32'h300C) begin n_fail++; $display("FAIL ws_adr: n %0d want 4 with 3008/300c", ack_adr.size()); end
    n_chk++; if (done_cyc !== 7 || d_beats !== 5'd4 || wcons !== 4) begin n_fail++; $display("FAIL ws_done: done@%0d beats %0d consumed %0d want 7/4/4", done_cyc, d_beats, wcons); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (mem[i] !== 32'hA0 + 32'(i)) begin n_fail++; $display("FAIL ws_mem%0d: got %h want %h", i, mem[i], 32'hA0 + 32'(i)); end
    end
  endtask

  task automatic test_retry;
    wr_data = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    stall_n = 0; rty_adr_t = 32'h4008; rty_target = rty_seen + 2;
    issue(1'b1, 32'h4000, 4'd3);
    run(30);
    n_chk++; if (rty_adr.size() !== 2 || rty_adr[0] !== 32'h4008 || rty_adr[1] !== 32'h4008) begin n_fail++; $display("FAIL rt_rty_adr: n %0d want 2 at 4008", rty_adr.size()); end
    n_chk++; if (gap_cnt !== 2 || done_cyc !== 8) begin n_fail++; $display("FAIL rt_gap: gaps %0d done@%0d want 2/8", gap_cnt, done_cyc); end
    n_chk++; if (d_err !== 1'b0 || d_beats !== 5'd4 || ack_adr.size() !== 4 || mem[2] !== 32'hB2) begin n_fail++; $display("FAIL rt_done: err %b beats %0d acks %0d mem %h want 0/4/4/b2", d_err, d_beats, ack_adr.size(), mem[2]); end
    wr_data.delete();
    rty_target = rty_seen + 4;
    issue(1'b0, 32'h4000, 4'd3);
    run(30);
    n_chk++; if (d_err !== 1'b1 || d_beats !== 5'd2 || done_cyc !== 9) begin n_fail++; $display("FAIL rx_done: err %b beats %0d done@%0d want 1/2/9", d_err, d_beats, done_cyc); end
    n_chk++; if (rty_adr.size() !== 4 || gap_cnt !== 3 || rd_dat.size() !== 2 || rd_at_done !== 1'b0) begin n_fail++; $display("FAIL rx_bus: rty %0d gaps %0d reads %0d rd@done %b want 4/3/2/0", rty_adr.size(), gap_cnt, rd_dat.size(), rd_at_done); end
  endtask

  task automatic test_err_wrap;
    wr_data.delete();
    err_en = 1'b1; err_adr_t = 32'h0;
    issue(1'b0, 32'hFFFF_FFF8, 4'd15);
    run(30);
    err_en = 1'b0;
    n_chk++; if (ack_adr.size() !== 2 || ack_adr[0] !== 32'hFFFF_FFF8 || ack_adr[1] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL ew_acks: n %0d want 2 at fffffff8/fffffffc", ack_adr.size()); end
    n_chk++; if (err_adr.size() !== 1 || err_adr[0] !== 32'h0) begin n_fail++; $display("FAIL ew_wrap: n %0d adr %h want 1/00000000", err_adr.size(), err_adr[0]); end
    n_chk++; if (d_err !== 1'b1 || d_beats !== 5'd2 || done_cyc !== 3) begin n_fail++; $display("FAIL ew_done: err %b beats %0d done@%0d want 1/2/3", d_err, d_beats, done_cyc); end
  endtask

  task automatic test_reset_mid;
    logic any_done = 1'b0;
    issue(1'b0, 32'h5000, 4'd15);
    for (int c = 0; c < 5; c++) begin @(negedge clk); #1; end
    n_chk++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h5010) begin n_fail++; $display("FAIL rm_beat5: cyc %b adr %h want 1/5010", wb_cyc_o, wb_adr_o); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || cmd_ready !== 1'b0 || done_valid !== 1'b0) begin n_fail++; $display("FAIL rm_drop: cyc %b stb %b rdy %b done %b want 0/0/0/0", wb_cyc_o, wb_stb_o, cmd_ready, done_valid); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %b want 1", cmd_ready); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (done_valid || wb_cyc_o) any_done = 1'b1;
    end
    n_chk++; if (any_done !== 1'b0) begin n_fail++; $display("FAIL rm_no_done: got %b want 0", any_done); end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0; cmd_len = '0;
    wdata = '0; wdata_valid = 1'b0; err_en = 1'b0; err_adr_t = '0; rty_adr_t = '0; rty_target = 0;
    stall_at = 0; stall_n = 0;
    test_reset();
    test_single();
    test_burst();
    test_wait_states();
    test_retry();
    test_err_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
